multicycle_control: RTL and testbench

Multi-cycle sequencer for the CPU datapath: replaces the single-cycle decode-and-fire control with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the enables, muxes and ALU command of the shared datapath (PC, IR, register file, ALU, data memory). It handshakes with instruction and data memory so multi-cycle memories stall the core cleanly.

---
 rtl/cpu_ctl_pkg.sv | 68 ++++++
 rtl/ctl_decode.sv | 41 ++++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctl_pkg.sv
// rtl/cpu_ctl_pkg.sv - shared encodings for the multi-cycle control path and datapath muxes
// Contents: FSM state encoding, opcode/funct constants, alu_cmd, pc_src,
//           reg_dst and wb_src encodings, decoded instruction classes.
package cpu_ctl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011
  } alu_cmd_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    RD_RT  = 2'd0,
    RD_RD  = 2'd1,
    RD_R31 = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_RALU,
    CLS_JR,
    CLS_ADDI,
    CLS_XORI,
    CLS_LW,
    CLS_SW,
    CLS_BNE,
    CLS_J,
    CLS_JAL
  } instr_class_e;

endpackage

// File: rtl/ctl_decode.sv
// rtl/ctl_decode.sv - combinational opcode/funct decode to instruction class and ALU command
// Ports: opcode, funct (in)  - IR fields
//        cls (out)            - instruction class
//        alu_cmd (out)        - ALU command used in EXEC
//        legal (out)          - instruction is in the supported set
module ctl_decode
  import cpu_ctl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output alu_cmd_e     alu_cmd,
  output logic         legal
);

  always_comb begin
    cls     = CLS_NONE;
    alu_cmd = ALU_ADD;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin cls = CLS_RALU; alu_cmd = ALU_ADD; end
          FN_SUB: begin cls = CLS_RALU; alu_cmd = ALU_SUB; end
          FN_SLT: begin cls = CLS_RALU; alu_cmd = ALU_SLT; end
          FN_JR:  cls = CLS_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_ADDI: cls = CLS_ADDI;
      OP_XORI: begin cls = CLS_XORI; alu_cmd = ALU_XOR; end
      OP_BNE:  begin cls = CLS_BNE;  alu_cmd = ALU_SUB; end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer for the shared datapath
// Inputs:  clk, reset_n (async, active low), opcode, funct, zero,
//          imem_ready, dmem_ready
// Outputs: imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write,
//          reg_write, reg_dst, wb_src, alu_src_imm, alu_cmd, state, illegal
// Option:  MULTICYCLE_CTL_PERF_EN adds cycle_count and instr_count (32-bit).
module multicycle_control
  import cpu_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        alu_src_imm,
  output logic [2:0]  alu_cmd,
  output logic [2:0]  state,
  output logic        illegal
`ifdef MULTICYCLE_CTL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e       state_q, state_d;
  logic         illegal_q, illegal_d;
  instr_class_e dec_cls;
  alu_cmd_e     dec_alu;
  logic         dec_legal;

  ctl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_cmd (dec_alu),
    .legal   (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!dec_legal) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_RALU, CLS_ADDI, CLS_XORI: state_d = ST_WB;
          CLS_LW, CLS_SW:               state_d = ST_MEM;
          default:                      state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  if (dmem_ready) state_d = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are gated by reset_n so that an asserted reset kills every
  // request and write strobe in the same instant, not at the next edge.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SEQ;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = RD_RT;
    wb_src      = WB_ALU;
    alu_src_imm = 1'b0;
    alu_cmd     = ALU_ADD;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        ST_EXEC: begin
          alu_cmd = dec_alu;
          case (dec_cls)
            CLS_ADDI, CLS_XORI, CLS_LW, CLS_SW: alu_src_imm = 1'b1;
            CLS_BNE: begin
              pc_write = ~zero;
              pc_src   = PC_BRANCH;
            end
            CLS_J: begin
              pc_write = 1'b1;
              pc_src   = PC_JUMP;
            end
            CLS_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_JUMP;
              reg_write = 1'b1;
              reg_dst   = RD_R31;
              wb_src    = WB_LINK;
            end
            CLS_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_REG;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (dec_cls == CLS_SW);
        end
        ST_WB: begin
          reg_write = 1'b1;
          if (dec_cls == CLS_RALU) reg_dst = RD_RD;
          if (dec_cls == CLS_LW)   wb_src  = WB_MEM;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MULTICYCLE_CTL_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (state_q != ST_TRAP) begin
      cycle_count_d = cycle_count_q + 32'd1;
      // Any FETCH entry from outside FETCH marks a retired instruction.
      if (state_q != ST_FETCH && state_d == ST_FETCH)
        instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control
module tb_multicycle_control;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_src;
  logic        alu_src_imm;
  logic [2:0]  alu_cmd;
  logic [2:0]  state;
  logic        illegal;
`ifdef MULTICYCLE_CTL_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  multicycle_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .wb_src      (wb_src),
    .alu_src_imm (alu_src_imm),
    .alu_cmd     (alu_cmd),
    .state       (state),
    .illegal     (illegal)
`ifdef MULTICYCLE_CTL_PERF_EN
    ,
    .cycle_count (cycle_count),
    .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write, reg_write,
  //  reg_dst, wb_src, alu_src_imm, alu_cmd}
  logic [15:0] ctl_now;
  assign ctl_now = {imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write,
                    reg_write, reg_dst, wb_src, alu_src_imm, alu_cmd};

  function automatic logic [15:0] cv(input logic im, input logic dm, input logic we,
                                     input logic pw, input logic [1:0] ps,
                                     input logic irw, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] wb,
                                     input logic imm, input logic [2:0] alu);
    return {im, dm, we, pw, ps, irw, rw, rd, wb, imm, alu};
  endfunction

  localparam logic [15:0] IDLE   = 16'h0000;
  localparam logic [15:0] F_GO   = 16'b1_0_0_1_00_1_0_00_00_0_000;
  localparam logic [15:0] F_WAIT = 16'b1_0_0_0_00_0_0_00_00_0_000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge: settle, check this cycle, advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [15:0] ec);
    #1;
    check({tag, "_state"}, {29'd0, state}, {29'd0, es});
    check({tag, "_ctl"}, {16'd0, ctl_now}, {16'd0, ec});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ctl", {16'd0, ctl_now}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;

    // ADD: 4 cycles, write to Rd in WB only
    cyc("add_f", 3'd0, F_GO);
    cyc("add_d", 3'd1, IDLE);
    cyc("add_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,0,3'd0));
    cyc("add_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd1,2'd0,0,3'd0));

    funct = 6'h22;
    cyc("sub_f", 3'd0, F_GO);
    cyc("sub_d", 3'd1, IDLE);
    cyc("sub_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,0,3'd1));
    cyc("sub_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd1,2'd0,0,3'd0));

    funct = 6'h2A;
    cyc("slt_f", 3'd0, F_GO);
    cyc("slt_d", 3'd1, IDLE);
    cyc("slt_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,0,3'd3));
    cyc("slt_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd1,2'd0,0,3'd0));

    opcode = 6'h08;
    cyc("addi_f", 3'd0, F_GO);
    cyc("addi_d", 3'd1, IDLE);
    cyc("addi_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,1,3'd0));
    cyc("addi_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd0,2'd0,0,3'd0));

    opcode = 6'h0E;
    cyc("xori_f", 3'd0, F_GO);
    cyc("xori_d", 3'd1, IDLE);
    cyc("xori_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,1,3'd2));
    cyc("xori_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd0,2'd0,0,3'd0));

    // SW with dmem_ready high the whole time: ignored outside MEM, 4 cycles
    opcode = 6'h2B; dmem_ready = 1'b1;
    cyc("sw_f", 3'd0, F_GO);
    cyc("sw_d", 3'd1, IDLE);
    cyc("sw_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,1,3'd0));
    cyc("sw_m", 3'd3, cv(0,1,1,0,2'd0,0,0,2'd0,2'd0,0,3'd0));

    // LW with one imem wait and dmem_ready delayed 3 cycles
    opcode = 6'h23; dmem_ready = 1'b0; imem_ready = 1'b0;
    cyc("lw_fw", 3'd0, F_WAIT);
    imem_ready = 1'b1;
    cyc("lw_f", 3'd0, F_GO);
    cyc("lw_d", 3'd1, IDLE);
    cyc("lw_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,1,3'd0));
    cyc("lw_m0", 3'd3, cv(0,1,0,0,2'd0,0,0,2'd0,2'd0,0,3'd0));
    cyc("lw_m1", 3'd3, cv(0,1,0,0,2'd0,0,0,2'd0,2'd0,0,3'd0));
    cyc("lw_m2", 3'd3, cv(0,1,0,0,2'd0,0,0,2'd0,2'd0,0,3'd0));
    dmem_ready = 1'b1;
    cyc("lw_m3", 3'd3, cv(0,1,0,0,2'd0,0,0,2'd0,2'd0,0,3'd0));
    dmem_ready = 1'b0;
    cyc("lw_wb", 3'd4, cv(0,0,0,0,2'd0,0,1,2'd0,2'd1,0,3'd0));

    opcode = 6'h05; zero = 1'b1;
    cyc("bnet_f", 3'd0, F_GO);
    cyc("bnet_d", 3'd1, IDLE);
    cyc("bnet_e", 3'd2, cv(0,0,0,0,2'd1,0,0,2'd0,2'd0,0,3'd1));

    zero = 1'b0;
    cyc("bnen_f", 3'd0, F_GO);
    cyc("bnen_d", 3'd1, IDLE);
    cyc("bnen_e", 3'd2, cv(0,0,0,1,2'd1,0,0,2'd0,2'd0,0,3'd1));

    opcode = 6'h02;
    cyc("j_f", 3'd0, F_GO);
    cyc("j_d", 3'd1, IDLE);
    cyc("j_e", 3'd2, cv(0,0,0,1,2'd2,0,0,2'd0,2'd0,0,3'd0));

    opcode = 6'h03;
    cyc("jal_f", 3'd0, F_GO);
    cyc("jal_d", 3'd1, IDLE);
    cyc("jal_e", 3'd2, cv(0,0,0,1,2'd2,0,1,2'd2,2'd2,0,3'd0));

    opcode = 6'h00; funct = 6'h08;
    cyc("jr_f", 3'd0, F_GO);
    cyc("jr_d", 3'd1, IDLE);
    cyc("jr_e", 3'd2, cv(0,0,0,1,2'd3,0,0,2'd0,2'd0,0,3'd0));

    // Reset in the middle of a stalled MEM access
    opcode = 6'h23;
    cyc("lwr_f", 3'd0, F_GO);
    cyc("lwr_d", 3'd1, IDLE);
    cyc("lwr_e", 3'd2, cv(0,0,0,0,2'd0,0,0,2'd0,2'd0,1,3'd0));
    #1;
    check("lwr_m_req", {31'd0, dmem_req}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("lwr_rst_state", {29'd0, state}, 32'd0);
    check("lwr_rst_ctl", {16'd0, ctl_now}, 32'd0);
    opcode = 6'h3F;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Undecodable opcode traps after DECODE and stays silent
    cyc("ill_f", 3'd0, F_GO);
    cyc("ill_d", 3'd1, IDLE);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    cyc("ill_t0", 3'd7, IDLE);
    cyc("ill_t1", 3'd7, IDLE);
    cyc("ill_t2", 3'd7, IDLE);
    check("ill_sticky", {31'd0, illegal}, 32'd1);

    // Reset clears the trap; unsupported R-type funct also traps
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("fn_rst_illegal", {31'd0, illegal}, 32'd0);
    opcode = 6'h00; funct = 6'h21;
    reset_n = 1'b1;
    cyc("fn_f", 3'd0, F_GO);
    cyc("fn_d", 3'd1, IDLE);
    cyc("fn_t", 3'd7, IDLE);
    check("fn_flag", {31'd0, illegal}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
